stereo_serial_tx: RTL
=====================

// Module: stereo_serial_tx
// PURPOSE
//   Source-side serializer for the FM stereo modulator's serial audio inputs.
//   Accepts parallel LEFT/RIGHT PCM samples through a valid/ready handshake and buffers one pair.
//   On each 48 kHz frame enable it shifts the pair out MSB-first on two serial lines, with a frame sync.
//   Drives the modulator's LEFTin/RIGHTin pins in test benches and in the FPGA audio front-end.
// PARAMETERS
//   DATA_W   18  sample width in bits (two's complement); equals serial frame length
//   CLK_DIV  4   clock cycles per serial bit (>=1); DATA_W*CLK_DIV+2 must be < clocks per 48 kHz period
// PORTS
//   clock         in   1       system clock; all logic on rising edge
//   reset         in   1       asynchronous, active-low reset
//   clken48kHz    in   1       one-cycle frame-start enable, 48 kHz
//   left_in       in   DATA_W  left sample
//   right_in      in   DATA_W  right sample
//   sample_valid  in   1       left_in/right_in valid this cycle
//   sample_ready  out  1       holding register empty; sample accepted when valid&&ready
//   LEFTout       out  1       serial left data, MSB first
//   RIGHTout      out  1       serial right data, MSB first
//   sync_out      out  1       high during MSB bit period of every frame
//   busy          out  1       high while a frame is being shifted
//   underrun      out  1       one-cycle pulse: frame started with holding register empty
//   frame_err     out  1       one-cycle pulse: clken48kHz arrived while not IDLE
// BEHAVIOUR
//   Reset (reset=0, async): LEFTout=RIGHTout=sync_out=busy=underrun=frame_err=0; sample_ready=1;
//     holding register empty; last-sent register=0; state IDLE; bit/divider counters=0.
//   Input buffer: one-deep holding register (hold_l, hold_r, hold_full). sample_ready = !hold_full.
//     Accepted on valid&&ready; hold_full set next cycle. Independent of serializer state.
//   FSM: IDLE -> LOAD -> SHIFT -> IDLE.
//     IDLE: on clken48kHz go to LOAD. If hold_full: frame data = hold pair, hold_full cleared.
//       Else: frame data = last-sent pair; underrun pulses in the LOAD cycle.
//     LOAD (1 cycle): shift regs loaded; last-sent register updated; counters cleared.
//     SHIFT: MSB on LEFTout/RIGHTout from the cycle after LOAD; each bit held exactly CLK_DIV cycles.
//       sync_out=1 for the first CLK_DIV cycles only. busy=1 across LOAD and SHIFT.
//       After bit DATA_W-1 completes: LEFTout=RIGHTout=0, busy=0, return to IDLE.
//   Latency: clken48kHz at cycle t -> MSB and sync_out visible from cycle t+2.
//     Frame occupies cycles t+2 .. t+1+DATA_W*CLK_DIV.
//   Simultaneous events:
//     clken48kHz while hold empty and sample accepted same cycle: frame underruns (sends last-sent);
//       the new sample stays held for the next frame.
//     clken48kHz in LOAD/SHIFT: ignored; frame_err pulses next cycle; frame continues undisturbed.
//   Width rules: serial bits sent verbatim (no rounding or saturation); bit counter wraps only via FSM exit.
//   Reset mid-frame: outputs forced to 0 at once; the partial frame is lost. After release the first
//     frame with no new sample transmits zeros (last-sent=0) and pulses underrun.
// TESTING
//   T1 reset: hold reset=0 -> all outputs 0, sample_ready=1; release, no clken -> outputs stay 0.
//   T2 nominal: accept L=18'h2AAAA, R=18'h15555, clken at t -> LEFTout 1,0,1,0... and RIGHTout
//      0,1,0,1... from t+2, each bit 4 cycles; sync_out high t+2..t+5; busy low at t+74.
//   T3 underrun: after T2 pulse clken with no new sample -> underrun pulse at t+1;
//      frame repeats 18'h2AAAA/18'h15555.
//   T4 frame_err: clken pulsed at frame bit 5 -> frame_err pulse next cycle; serial stream identical to T2.
//   T5 back-pressure: present L=18'h00001 then L=18'h3FFFF back-to-back -> first accepted, ready=0
//      until the next LOAD consumes it; second accepted the cycle after; two frames send 00001 then 3FFFF.
//   T6 reset mid-frame at bit 7 -> LEFTout/RIGHTout/busy=0 immediately; release then clken ->
//      underrun pulse and an all-zero frame.

Source files
------------

// File: rtl/stereo_serial_tx.sv
// Parallel-to-serial stereo PCM source: one-deep input buffer, then an MSB-first
// frame on LEFTout/RIGHTout with a one-bit-period sync on each frame enable.
module stereo_serial_tx #(
  parameter int DATA_W  = 18,
  parameter int CLK_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clken48kHz,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              LEFTout,
  output logic              RIGHTout,
  output logic              sync_out,
  output logic              busy,
  output logic              underrun,
  output logic              frame_err
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] hold_l, hold_r, last_l, last_r, sh_l, sh_r;
  logic              hold_full;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              accept, start, bit_end, frame_end;

  assign accept    = sample_valid && !hold_full;
  assign start     = (state == IDLE) && clken48kHz;
  assign bit_end   = (div_cnt == DW'(CLK_DIV - 1));
  assign frame_end = bit_end && (bit_cnt == BW'(DATA_W - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clken48kHz) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame data is captured into the shift registers on the enable edge rather
  // than in LOAD; the serial output is gated by SHIFT, so the timing is identical.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      last_l    <= '0;
      last_r    <= '0;
      sh_l      <= '0;
      sh_r      <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      underrun  <= start && !hold_full;
      frame_err <= clken48kHz && (state != IDLE);

      if (accept) begin
        hold_l    <= left_in;
        hold_r    <= right_in;
        hold_full <= 1'b1;
      end else if (start && hold_full) begin
        hold_full <= 1'b0;
      end

      if (start) begin
        if (hold_full) begin
          sh_l   <= hold_l;
          sh_r   <= hold_r;
          last_l <= hold_l;
          last_r <= hold_r;
        end else begin
          sh_l <= last_l;
          sh_r <= last_r;
        end
      end

      if (state == LOAD) begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        if (bit_end) begin
          div_cnt <= '0;
          bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
          sh_l    <= {sh_l[DATA_W-2:0], 1'b0};
          sh_r    <= {sh_r[DATA_W-2:0], 1'b0};
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  assign sample_ready = !hold_full;
  assign LEFTout      = (state == SHIFT) && sh_l[DATA_W-1];
  assign RIGHTout     = (state == SHIFT) && sh_r[DATA_W-1];
  assign sync_out     = (state == SHIFT) && (bit_cnt == '0);
  assign busy         = (state != IDLE);

endmodule
